mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl_if.sv | 27 ++
 rtl/mul_seq_ctrl.sv | 109 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - request/result and arithmetic-unit signals of the sequential multiplier
interface mul_seq_ctrl_if;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf8;
  logic [1:0]  alu_s;
  logic        alu_cin;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_sum;
  logic        alu_cout;

  // The controller is the slave of the requester and drives the external 8-bit adder.
  modport slave (
    input  start, mcand, mplier, alu_sum, alu_cout,
    output busy, done, product, ovf8, alu_s, alu_cin, alu_a, alu_b
  );

  modport master (
    output start, mcand, mplier, alu_sum, alu_cout,
    input  busy, done, product, ovf8, alu_s, alu_cin, alu_a, alu_b
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - 8x8 unsigned shift-add multiplier sequencing an external 8-bit adder
module mul_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  mc_q, mc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic        ovf8_q, ovf8_d;

  logic [1:0]  alu_s_c;
  logic [7:0]  alu_a_c;
  logic [7:0]  alu_b_c;
  logic        busy_c;
  logic        done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= 8'd0;
      lo_q      <= 8'd0;
      mc_q      <= 8'd0;
      cnt_q     <= 3'd0;
      product_q <= 16'd0;
      ovf8_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mc_q      <= mc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf8_q    <= ovf8_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mc_d      = mc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf8_d    = ovf8_q;
    alu_s_c   = 2'b00;
    alu_a_c   = 8'd0;
    alu_b_c   = 8'd0;
    busy_c    = 1'b0;
    done_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          hi_d    = 8'd0;
          lo_d    = bus.mplier;
          mc_d    = bus.mcand;
          cnt_d   = 3'd0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        busy_c  = 1'b1;
        alu_a_c = hi_q;
        alu_b_c = mc_q;
        // A clear multiplier bit selects A+Cin, passing hi through with carry-out 0.
        alu_s_c = lo_q[0] ? 2'b01 : 2'b00;
        hi_d    = {bus.alu_cout, bus.alu_sum[7:1]};
        lo_d    = {bus.alu_sum[0], lo_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          product_d = {hi_d, lo_d};
          ovf8_d    = (hi_d != 8'd0);
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.product = product_q;
  assign bus.ovf8    = ovf8_q;
  assign bus.alu_s   = alu_s_c;
  assign bus.alu_cin = 1'b0;
  assign bus.alu_a   = alu_a_c;
  assign bus.alu_b   = alu_b_c;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - randomized self-checking bench for mul_seq_ctrl against arithmetic products
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_seq_ctrl_if bus();

  mul_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 8-bit arithmetic unit: 01 = A+B+Cin, anything else = A+Cin.
  assign {bus.alu_cout, bus.alu_sum} = (bus.alu_s == 2'b01)
      ? ({1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin})
      : ({1'b0, bus.alu_a} + {8'd0, bus.alu_cin});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One multiply; operands and start are scrambled after acceptance to prove capture.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit noisy,
                         output bit seen_cout);
    logic [15:0] exp_p;
    int          cyc;
    int          execs;
    bit          seen_done;
    exp_p     = 16'(a) * 16'(b);
    seen_cout = 1'b0;
    seen_done = 1'b0;
    cyc       = 0;
    execs     = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    while (!seen_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        seen_done = 1'b1;
        bus.start = 1'b0;
        check("latency", cyc, 9);
        check("busy_in_done", bus.busy, 1'b0);
        check("product", bus.product, exp_p);
        check("ovf8", bus.ovf8, exp_p[15:8] != 8'd0);
      end else if (bus.busy) begin
        execs++;
        if (execs <= 8) begin
          check("alu_s", bus.alu_s, {1'b0, b[execs-1]});
          check("alu_b", bus.alu_b, a);
        end
        check("alu_cin", bus.alu_cin, 1'b0);
        if (bus.alu_cout) seen_cout = 1'b1;
        bus.mcand  = 8'($urandom);
        bus.mplier = 8'($urandom);
        bus.start  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        check("busy_exec", bus.busy, 1'b1);
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("done_seen", seen_done, 1'b1);
    check("exec_cycles", execs, 8);
    @(negedge clk);
    check("done_width", bus.done, 1'b0);
    check("busy_after", bus.busy, 1'b0);
    check("product_hold", bus.product, exp_p);
  endtask

  bit          cout_flag;
  logic [7:0]  ra, rb, a2, b2;
  logic [15:0] exp_q[$];
  int          done_cyc[$];
  int          n_done;

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.mcand  = 8'd0;
    bus.mplier = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_product", bus.product, 16'd0);
    check("rst_ovf8", bus.ovf8, 1'b0);
    check("rst_alu_s", bus.alu_s, 2'b00);
    check("rst_alu_a", bus.alu_a, 8'd0);
    check("rst_alu_b", bus.alu_b, 8'd0);
    check("rst_alu_cin", bus.alu_cin, 1'b0);
    rst_n = 1'b1;

    run_mul(8'd13, 8'd11, 1'b0, cout_flag);
    run_mul(8'hFF, 8'hFF, 1'b1, cout_flag);
    check("cout_seen_ff", cout_flag, 1'b1);
    run_mul(8'hA5, 8'h00, 1'b1, cout_flag);
    run_mul(8'd13, 8'd11, 1'b0, cout_flag);

    // Reset in the 4th EXEC cycle aborts the operation.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 8'($urandom_range(1, 255));
    bus.mplier = 8'($urandom_range(1, 255));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_product", bus.product, 16'd0);
    check("abort_ovf8", bus.ovf8, 1'b0);
    check("abort_alu_s", bus.alu_s, 2'b00);
    check("abort_alu_a", bus.alu_a, 8'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_product_hold", bus.product, 16'd0);
    run_mul(8'd3, 8'd7, 1'b0, cout_flag);

    // start held high: second operation accepted only after DONE.
    ra = 8'($urandom);
    rb = 8'($urandom);
    a2 = 8'($urandom);
    b2 = 8'($urandom);
    exp_q.push_back(16'(ra) * 16'(rb));
    exp_q.push_back(16'(a2) * 16'(b2));
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = ra;
    bus.mplier = rb;
    @(negedge clk);
    bus.mcand  = a2;
    bus.mplier = b2;
    for (int c = 1; c <= 30; c++) begin
      if (bus.done) begin
        done_cyc.push_back(c);
        if (exp_q.size() != 0) check("b2b_product", bus.product, exp_q.pop_front());
        if (done_cyc.size() == 2) bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_pulses", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("b2b_period", done_cyc[1] - done_cyc[0], 10);
    check("b2b_idle_after", bus.busy, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run_mul(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), cout_flag);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
